// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the datapath selects, write enables and ALU control.
//
//  state   | meaning
//  --------+---------------------------------------------
//  FETCH   | read instruction at PC, PC <= PC + 4
//  DECODE  | read registers, branch target into ALUOut
//  MEMADR  | lw/sw effective address
//  MEMRD   | data memory read at ALUOut
//  MEMWB   | MDR -> rt
//  MEMWR   | data memory write at ALUOut
//  RTYPEEX | R-type ALU operation
//  RTYPEWB | ALUOut -> rd
//  BEQEX   | compare, load PC from ALUOut when equal
//  ADDIEX  | regA + signimm
//  ADDIWB  | ALUOut -> rt
//  JEX     | load PC with jump target
//  HALT    | parked after an illegal instruction (trap mode)
module mc_controller #(
  parameter bit TRAP_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       pcen,
  output logic       iord,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucont,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JEX     = 4'd11;
  localparam logic [3:0] S_HALT    = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       op_legal;
  logic       funct_legal;
  logic [2:0] funct_alu;
  logic       pcwrite;
  logic       branch;

  assign state = state_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    op_legal = 1'b1;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
      default:                                       op_legal = 1'b0;
    endcase
  end

  always_comb begin
    funct_legal = 1'b1;
    funct_alu   = ALU_ADD;
    case (funct)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_SLT:  funct_alu = ALU_SLT;
      default: funct_legal = 1'b0;
    endcase
  end

  // Unused codes 13-15 fall through to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default:      state_d = TRAP_ILLEGAL ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = S_MEMWB;
      S_RTYPEEX: begin
        if (funct_legal)       state_d = S_RTYPEWB;
        else if (TRAP_ILLEGAL) state_d = S_HALT;
        else                   state_d = S_FETCH;
      end
      S_ADDIEX:  state_d = S_ADDIWB;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_FETCH;
    endcase
  end

  // While reset is high the FETCH selects are shown but every enable is held low.
  always_comb begin
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    iord     = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    alucont  = ALU_ADD;
    illegal  = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    case (reset ? S_FETCH : state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = 1'b1;
        pcwrite = 1'b1;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        illegal = ~op_legal;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        alucont = funct_alu;
        illegal = ~funct_legal;
      end
      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        alucont = ALU_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
    pcen = pcwrite | (branch & zero);
    if (reset) begin
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      pcen     = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule
